updown_counter_bounded: RTL and testbench

- Parametrised successor to the single-step 32-bit up/down counter.
- Adds run-time lower/upper bounds, programmable step, parallel load, count enable, wrap-or-saturate mode, and boundary event outputs.
- Used as a general sequencing/credit counter in test designs; single clock domain, registered count output.

---
 rtl/updown_pkg.sv | 12 +
 rtl/updown_next_calc.sv | 59 +++++
 rtl/updown_counter_bounded.sv | 89 ++++++++
 tb/tb_updown_counter_bounded.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/updown_pkg.sv
// Shared constants for the bounded up/down counter.
//   DIR_UP / DIR_DOWN    : encoding of the direction input
//   MODE_WRAP / MODE_SAT : encoding of the boundary-behaviour input
package updown_pkg;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage : updown_pkg

// File: rtl/updown_next_calc.sv
// Combinational next-count calculation for the bounded up/down counter.
// Ports:
//   value      : current count
//   step       : magnitude added or subtracted
//   inst       : direction (DIR_UP / DIR_DOWN)
//   sat_mode   : MODE_WRAP / MODE_SAT
//   limit_lo   : inclusive lower bound
//   limit_hi   : inclusive upper bound
//   next_value : count to take if this cycle counts
//   hit_hi     : up-count crossed limit_hi
//   hit_lo     : down-count crossed limit_lo
module updown_next_calc
    import updown_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic [WIDTH-1:0] step,
    input  logic             inst,
    input  logic             sat_mode,
    input  logic [WIDTH-1:0] limit_lo,
    input  logic [WIDTH-1:0] limit_hi,
    output logic [WIDTH-1:0] next_value,
    output logic             hit_hi,
    output logic             hit_lo
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           step_nz;

    // One extra bit keeps the carry/borrow visible to the bound compares.
    assign sum     = {1'b0, value} + {1'b0, step};
    assign diff    = {1'b0, value} - {1'b0, step};
    assign step_nz = (step != '0);

    // A zero step never counts as a boundary, even from an out-of-range load.
    assign hit_hi = (inst == DIR_UP) && step_nz && (sum > {1'b0, limit_hi});
    assign hit_lo = (inst == DIR_DOWN) && step_nz &&
                    (diff[WIDTH] || (diff < {1'b0, limit_lo}));

    always_comb begin
        next_value = value;
        if (inst == DIR_UP) begin
            if (hit_hi) begin
                next_value = (sat_mode == MODE_SAT) ? limit_hi : limit_lo;
            end else begin
                next_value = sum[WIDTH-1:0];
            end
        end else begin
            if (hit_lo) begin
                next_value = (sat_mode == MODE_SAT) ? limit_lo : limit_hi;
            end else begin
                next_value = diff[WIDTH-1:0];
            end
        end
    end

endmodule : updown_next_calc

// File: rtl/updown_counter_bounded.sv
// Bounded up/down counter with programmable step, parallel load,
// wrap-or-saturate boundary handling and boundary event pulses.
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   enable, inst        : count enable, direction (0 up, 1 down)
//   step, sat_mode      : count magnitude, 0 wrap / 1 saturate
//   load, load_value    : parallel load strobe and data
//   limit_lo, limit_hi  : inclusive bounds
//   value               : registered count
//   at_min, at_max      : value sits on a bound
//   overflow, underflow : one-cycle registered boundary pulses
//   cfg_err             : limit_lo > limit_hi (counting suppressed)
module updown_counter_bounded
    import updown_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             inst,
    input  logic [WIDTH-1:0] step,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] limit_lo,
    input  logic [WIDTH-1:0] limit_hi,
    output logic [WIDTH-1:0] value,
    output logic             at_min,
    output logic             at_max,
    output logic             overflow,
    output logic             underflow,
    output logic             cfg_err
);

    logic [WIDTH-1:0] value_q, value_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] calc_value;
    logic             hit_hi, hit_lo;

    updown_next_calc #(.WIDTH(WIDTH)) u_next_calc (
        .value      (value_q),
        .step       (step),
        .inst       (inst),
        .sat_mode   (sat_mode),
        .limit_lo   (limit_lo),
        .limit_hi   (limit_hi),
        .next_value (calc_value),
        .hit_hi     (hit_hi),
        .hit_lo     (hit_lo)
    );

    assign cfg_err = (limit_lo > limit_hi);

    // Load beats counting; pulses are only raised by a qualifying count.
    always_comb begin
        value_d = value_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (load) begin
            value_d = load_value;
        end else if (enable && !cfg_err) begin
            value_d = calc_value;
            ovf_d   = hit_hi;
            unf_d   = hit_lo;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            value_q <= RESET_VALUE;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign value     = value_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign at_min    = (value_q == limit_lo);
    assign at_max    = (value_q == limit_hi);

endmodule : updown_counter_bounded

// File: tb/tb_updown_counter_bounded.sv
module tb_updown_counter_bounded;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset, enable, inst, sat_mode, load;
    logic [W-1:0] step, load_value, limit_lo, limit_hi;
    logic [W-1:0] value;
    logic         at_min, at_max, overflow, underflow, cfg_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string        tag;
        logic [W-1:0] v;
        logic         ov;
        logic         un;
        logic         amin;
        logic         amax;
        logic         cerr;
    } exp_t;

    exp_t sb[$];

    always #5 clock = ~clock;

    updown_counter_bounded #(.WIDTH(W), .RESET_VALUE(8'h05)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .inst       (inst),
        .step       (step),
        .sat_mode   (sat_mode),
        .load       (load),
        .load_value (load_value),
        .limit_lo   (limit_lo),
        .limit_hi   (limit_hi),
        .value      (value),
        .at_min     (at_min),
        .at_max     (at_max),
        .overflow   (overflow),
        .underflow  (underflow),
        .cfg_err    (cfg_err)
    );

    // Push the expected post-edge state, clock once, then pop and compare.
    task automatic step_chk(input string tag, input logic [W-1:0] ev,
                            input logic eo, input logic eu);
        exp_t e;
        e.tag  = tag;
        e.v    = ev;
        e.ov   = eo;
        e.un   = eu;
        e.amin = (ev == limit_lo);
        e.amax = (ev == limit_hi);
        e.cerr = (limit_lo > limit_hi);
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        checks++;
        assert (value === e.v) else begin
            errors++;
            $error("FAIL %s value: got %0d, want %0d", e.tag, value, e.v);
        end
        checks++;
        assert (overflow === e.ov) else begin
            errors++;
            $error("FAIL %s overflow: got %b, want %b", e.tag, overflow, e.ov);
        end
        checks++;
        assert (underflow === e.un) else begin
            errors++;
            $error("FAIL %s underflow: got %b, want %b", e.tag, underflow, e.un);
        end
        checks++;
        assert (at_min === e.amin) else begin
            errors++;
            $error("FAIL %s at_min: got %b, want %b", e.tag, at_min, e.amin);
        end
        checks++;
        assert (at_max === e.amax) else begin
            errors++;
            $error("FAIL %s at_max: got %b, want %b", e.tag, at_max, e.amax);
        end
        checks++;
        assert (cfg_err === e.cerr) else begin
            errors++;
            $error("FAIL %s cfg_err: got %b, want %b", e.tag, cfg_err, e.cerr);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; inst = 1'b0; sat_mode = 1'b0; load = 1'b0;
        step = 8'd1; load_value = 8'd0; limit_lo = 8'd0; limit_hi = 8'd255;

        step_chk("rst0", 8'd5, 1'b0, 1'b0);
        step_chk("rst1", 8'd5, 1'b0, 1'b0);
        reset = 1'b0;
        step_chk("hold0", 8'd5, 1'b0, 1'b0);
        step_chk("hold1", 8'd5, 1'b0, 1'b0);

        // Wrap on up-count past limit_hi
        limit_lo = 8'd10; limit_hi = 8'd20; step = 8'd3; sat_mode = 1'b0;
        load = 1'b1; load_value = 8'd18;
        step_chk("wrap_load", 8'd18, 1'b0, 1'b0);
        load = 1'b0; enable = 1'b1; inst = 1'b0;
        step_chk("wrap_up", 8'd10, 1'b1, 1'b0);
        step_chk("wrap_up2", 8'd13, 1'b0, 1'b0);

        // Saturate on down-count, repeated pulse while pinned
        sat_mode = 1'b1; enable = 1'b0; load = 1'b1; load_value = 8'd12;
        step_chk("sat_load", 8'd12, 1'b0, 1'b0);
        load = 1'b0; enable = 1'b1; inst = 1'b1; step = 8'd5;
        step_chk("sat_dn", 8'd10, 1'b0, 1'b1);
        step_chk("sat_dn2", 8'd10, 1'b0, 1'b1);
        enable = 1'b0;
        step_chk("sat_idle", 8'd10, 1'b0, 1'b0);

        // Full-range carry / borrow
        limit_lo = 8'd0; limit_hi = 8'd255; step = 8'd1; sat_mode = 1'b0;
        load = 1'b1; load_value = 8'hFF;
        step_chk("full_load", 8'hFF, 1'b0, 1'b0);
        load = 1'b0; enable = 1'b1; inst = 1'b0;
        step_chk("carry", 8'h00, 1'b1, 1'b0);
        inst = 1'b1;
        step_chk("borrow", 8'hFF, 1'b0, 1'b1);
        sat_mode = 1'b1; inst = 1'b0;
        step_chk("sat_carry", 8'hFF, 1'b1, 1'b0);
        sat_mode = 1'b0; inst = 1'b1; step = 8'd3;
        step_chk("dn_plain", 8'hFC, 1'b0, 1'b0);

        // Priority: load over enable, reset over load
        load = 1'b1; load_value = 8'd7; enable = 1'b1;
        step_chk("load_pri", 8'd7, 1'b0, 1'b0);
        reset = 1'b1; load_value = 8'd9;
        step_chk("rst_pri", 8'd5, 1'b0, 1'b0);
        reset = 1'b0; load = 1'b0;
        step_chk("dn_after_rst", 8'd2, 1'b0, 1'b0);
        reset = 1'b1;
        step_chk("rst_midcount", 8'd5, 1'b0, 1'b0);
        reset = 1'b0;

        // Inverted bounds suppress counting but not load
        limit_lo = 8'd30; limit_hi = 8'd20; enable = 1'b1; inst = 1'b0; step = 8'd1;
        step_chk("cfg_hold", 8'd5, 1'b0, 1'b0);
        load = 1'b1; load_value = 8'd25;
        step_chk("cfg_load", 8'd25, 1'b0, 1'b0);
        load = 1'b0;
        step_chk("cfg_hold2", 8'd25, 1'b0, 1'b0);

        // Zero step holds even from an out-of-range value
        limit_lo = 8'd10; limit_hi = 8'd20; step = 8'd0;
        step_chk("step0_up", 8'd25, 1'b0, 1'b0);
        inst = 1'b1;
        step_chk("step0_dn", 8'd25, 1'b0, 1'b0);
        load = 1'b1; load_value = 8'd20;
        step_chk("at_hi_load", 8'd20, 1'b0, 1'b0);
        load = 1'b0; inst = 1'b0;
        step_chk("step0_at_hi", 8'd20, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_updown_counter_bounded
